// File: rtl/cipher_pkg.sv
// cipher_pkg: shared constants and helpers for the cipher pipeline.
//   PERM / PERM_INV : bit-index tables, out[i] = in[TABLE[i]]
//   K_DEF           : reset values of key slots 0..2 (one byte, replicated per lane)
//   mode_e          : per-beat direction (MODE_DEC / MODE_ENC)
//   perm_byte       : decrypt-direction byte permutation P
//   perm_inv_byte   : encrypt-direction byte permutation Pinv
package cipher_pkg;

    typedef enum logic {
        MODE_DEC = 1'b0,
        MODE_ENC = 1'b1
    } mode_e;

    // out[7:0] = {x3,x4,x6,x2,x1,x5,x0,x7}
    localparam int unsigned PERM [8] = '{7, 0, 5, 1, 2, 6, 4, 3};
    // out[7:0] = {y0,y5,y2,y6,y7,y4,y3,y1}
    localparam int unsigned PERM_INV [8] = '{1, 3, 4, 7, 6, 2, 5, 0};

    localparam logic [7:0] K_DEF [3] = '{8'h3E, 8'h49, 8'h7E};

    function automatic logic [7:0] perm_byte(input logic [7:0] x);
        logic [7:0] y;
        y = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            y[i] = x[PERM[i]];
        end
        return y;
    endfunction

    function automatic logic [7:0] perm_inv_byte(input logic [7:0] x);
        logic [7:0] y;
        y = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            y[i] = x[PERM_INV[i]];
        end
        return y;
    endfunction

    // Slots beyond the three defaults come up as zero.
    function automatic logic [7:0] default_key(input int unsigned slot);
        logic [7:0] k;
        case (slot)
            0:       k = K_DEF[0];
            1:       k = K_DEF[1];
            2:       k = K_DEF[2];
            default: k = 8'h00;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/cipher_lane_perm.sv
// cipher_lane_perm: combinational permutation of one byte lane.
//   dir  : MODE_DEC selects P, MODE_ENC selects Pinv
//   din  : input byte
//   dout : permuted byte
module cipher_lane_perm
    import cipher_pkg::*;
(
    input  mode_e      dir,
    input  logic [7:0] din,
    output logic [7:0] dout
);

    always_comb begin
        dout = (dir == MODE_ENC) ? perm_inv_byte(din) : perm_byte(din);
    end

endmodule

// File: rtl/cipher_pipe.sv
// cipher_pipe: bidirectional two-stage byte cipher with a rotating key ring.
//   Decrypt: out = P(in ^ K[i]);  Encrypt: out = Pinv(in) ^ K[i].
// Ports:
//   clock, rst                   : clock (rising edge), async active-high reset
//   in_valid/in_ready            : input handshake, beat taken on both high
//   in_data, in_mode, in_sof     : input word, direction (1 = encrypt), frame start
//   out_valid/out_ready          : output handshake
//   out_data                     : result word
//   key_we, key_idx, key_data    : key slot write port
module cipher_pipe
    import cipher_pkg::*;
#(
    parameter  int unsigned LANES    = 1,
    parameter  int unsigned NUM_KEYS = 3,
    localparam int unsigned N        = 8 * LANES,
    localparam int unsigned KW       = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
    input  logic          clock,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_data,
    input  logic          in_mode,
    input  logic          in_sof,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_data,
    input  logic          key_we,
    input  logic [KW-1:0] key_idx,
    input  logic [N-1:0]  key_data
);

    logic [N-1:0]  keys [NUM_KEYS];
    logic [KW-1:0] kidx;
    logic [KW-1:0] kidx_use;
    logic [KW-1:0] kidx_next;
    logic [N-1:0]  key_sel;

    mode_e         in_mode_e;
    logic          s1_valid;
    mode_e         s1_mode;
    logic [N-1:0]  s1_key;
    logic [N-1:0]  s1_data;
    logic [N-1:0]  s1_perm;
    logic [N-1:0]  s1_result;
    logic [N-1:0]  s2_perm;
    logic [N-1:0]  s2_result;

    logic          s1_ready;
    logic          s2_ready;
    logic          accept;

    // Handshake: a full output register frees up as the sink takes it, so
    // the ready chain is combinational back to in_ready.
    always_comb begin
        s2_ready = !out_valid || out_ready;
        s1_ready = !s1_valid || s2_ready;
        in_ready = s1_ready;
        accept   = in_valid && s1_ready;
    end

    // Key index for this beat and its successor, wrapping at NUM_KEYS.
    always_comb begin
        in_mode_e = mode_e'(in_mode);
        kidx_use  = in_sof ? '0 : kidx;
        kidx_next = (kidx_use == KW'(NUM_KEYS - 1)) ? '0 : kidx_use + KW'(1);
        key_sel   = keys[kidx_use];
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        cipher_lane_perm u_s1_perm (
            .dir  (in_mode_e),
            .din  (in_data[8*l +: 8]),
            .dout (s1_perm[8*l +: 8])
        );
        cipher_lane_perm u_s2_perm (
            .dir  (s1_mode),
            .din  (s1_data[8*l +: 8]),
            .dout (s2_perm[8*l +: 8])
        );
    end

    always_comb begin
        s1_result = (in_mode_e == MODE_ENC) ? s1_perm : (in_data ^ key_sel);
        s2_result = (s1_mode == MODE_ENC) ? (s1_data ^ s1_key) : s2_perm;
    end

    // Key ring. A write lands on the clock edge, so a beat accepted on the
    // same edge still reads the old slot value through key_sel.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            for (int unsigned s = 0; s < NUM_KEYS; s++) begin
                keys[s] <= {LANES{default_key(s)}};
            end
        end else if (key_we && (32'(key_idx) < NUM_KEYS)) begin
            keys[key_idx] <= key_data;
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            kidx      <= '0;
            s1_valid  <= 1'b0;
            s1_mode   <= MODE_DEC;
            s1_key    <= '0;
            s1_data   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (s1_ready) begin
                s1_valid <= in_valid;
            end
            if (accept) begin
                s1_mode <= in_mode_e;
                s1_key  <= key_sel;
                s1_data <= s1_result;
                kidx    <= kidx_next;
            end
            if (s2_ready) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    out_data <= s2_result;
                end
            end
        end
    end

endmodule
